bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter N_PORTS, default 2: number of requester ports; legal range 1..8.
REQ-002 Parameter XLEN, default 32: address and data width; XLEN is 32 or 64.
REQ-003 Parameter TIMEOUT, default 255: maximum wait in BUSY for i_ack, in cycles; 0 disables timeout.
REQ-004 Localparam BE = XLEN/8: byte-enable width per transaction.
REQ-005 i_clk  in  1  clock; all state updates on its rising edge.
REQ-006 i_rst  in  1  reset, synchronous, active-low.
REQ-007 i_req  in  N_PORTS  per-port request; held high until that port's o_ready pulse.
REQ-008 i_wr  in  N_PORTS  per-port direction: 1 = write, 0 = read.
REQ-009 i_addr  in  N_PORTS*XLEN  per-port address; port p occupies bits [p*XLEN +: XLEN].
REQ-010 i_wdata  in  N_PORTS*XLEN  per-port write data, packed the same way as i_addr.
REQ-011 i_ben  in  N_PORTS*BE  per-port byte enables.
REQ-012 o_ready  out  N_PORTS  per-port completion pulse.
REQ-013 o_err  out  N_PORTS  per-port error flag, valid only with o_ready.
REQ-014 o_rdata  out  XLEN  read data, shared by all ports.
REQ-015 i_ack  in  1  bus completion.
REQ-016 i_rd_data  in  XLEN  bus read data.
REQ-017 o_bus_en, o_wr_en  out  1 each  bus valid and bus direction.
REQ-018 o_addr, o_wr_data  out  XLEN each  bus address and bus write data.
REQ-019 o_byte_en  out  BE  bus byte enables.

Function
REQ-020 The arbiter SHALL be an FSM with two states, IDLE and BUSY, plus a registered grant index g and a round-robin pointer rr.
REQ-021 IDLE, any i_req high: grant the first requesting port scanning upward from rr, wrapping modulo N_PORTS; latch g; enter BUSY at the next edge.
REQ-022 The same edge SHALL register the bus outputs:
  - o_bus_en = 1
  - o_wr_en = i_wr[g]
  - o_addr = i_addr of port g; writes force the low log2(BE) bits to 0
  - o_wr_data and o_byte_en from port g
REQ-023 In BUSY, o_addr, o_wr_data, o_byte_en and o_wr_en SHALL hold constant, ignoring changes on requester inputs.
REQ-024 BUSY, i_ack high, same cycle (combinational): o_ready[g] = 1; o_err[g] = 0; for reads o_rdata = i_rd_data.
REQ-025 BUSY, i_ack high, next edge: o_bus_en = 0; o_wr_en = 0; rr = (g+1) mod N_PORTS; state = IDLE.
REQ-026 o_ready, o_err and o_rdata SHALL be 0 in every cycle in which REQ-024 and REQ-029 do not apply.
REQ-027 o_bus_en SHALL be low for at least one cycle between consecutive transactions; minimum transaction length is 2 cycles (grant edge to ack).
REQ-028 A wait counter SHALL clear on entry to BUSY and increment each BUSY cycle without i_ack, saturating and never wrapping.
REQ-029 TIMEOUT != 0 and counter == TIMEOUT without i_ack:
  - same cycle: o_ready[g] = 1, o_err[g] = 1
  - next edge: o_bus_en = 0, advance rr, state = IDLE
REQ-030 i_ack and timeout in the same cycle: i_ack wins and o_err stays 0.
REQ-031 i_req[g] falls during BUSY (requester abort): drop o_bus_en at the next edge, return to IDLE, leave rr unchanged, no o_ready pulse.
REQ-032 A late i_ack arriving in IDLE SHALL be ignored.
REQ-033 Ports requesting in the same IDLE cycle SHALL be served rr-first; no port waits more than N_PORTS-1 transactions.
REQ-034 N_PORTS = 1: g and rr are constant 0 and behaviour is otherwise identical.

Reset
REQ-035 i_rst low at a clock edge: state = IDLE, g = 0, rr = 0, counter = 0; all registered outputs 0.
REQ-036 Reset asserted mid-transaction: o_bus_en = 0 from the next edge, and no o_ready is generated for the aborted transaction.

Verification
REQ-037 N_PORTS=2, port 0 read at 0x100, i_ack 3 cycles after o_bus_en with i_rd_data=0xDEADBEEF -> o_ready[0] and o_rdata=0xDEADBEEF in the ack cycle; o_bus_en low next cycle.
REQ-038 Port 1 write at addr 0x203, wdata 0x55, ben 4'b0010 -> o_addr=0x200, o_wr_en=1, o_byte_en=4'b0010, until ack.
REQ-039 Ports 0 and 1 request together, continuously, for 4 transactions from reset -> grant order 0,1,0,1; o_bus_en low exactly 1 cycle between each.
REQ-040 TIMEOUT=4, no ack -> o_ready[g]=o_err[g]=1 in the 4th BUSY cycle; IDLE next; ack and timeout in the same cycle -> o_err=0.
REQ-041 i_req[g] dropped in the 2nd BUSY cycle -> o_bus_en=0 next edge, no o_ready, same port regranted first on re-request.
REQ-042 i_rst low during BUSY -> all outputs 0 next cycle; first grant after reset goes to port 0.

Source files
------------

// File: rtl/bus_arbiter_if.sv
// Requester-side and bus-side signals of the round-robin bus arbiter.
// master = arbiter view, slave = requesters plus bus target.
interface bus_arbiter_if #(
  parameter int N_PORTS = 2,
  parameter int XLEN    = 32
);
  localparam int BE = XLEN / 8;

  logic [N_PORTS-1:0]      i_req;
  logic [N_PORTS-1:0]      i_wr;
  logic [N_PORTS*XLEN-1:0] i_addr;
  logic [N_PORTS*XLEN-1:0] i_wdata;
  logic [N_PORTS*BE-1:0]   i_ben;
  logic [N_PORTS-1:0]      o_ready;
  logic [N_PORTS-1:0]      o_err;
  logic [XLEN-1:0]         o_rdata;

  logic                    i_ack;
  logic [XLEN-1:0]         i_rd_data;
  logic                    o_bus_en;
  logic                    o_wr_en;
  logic [XLEN-1:0]         o_addr;
  logic [XLEN-1:0]         o_wr_data;
  logic [BE-1:0]           o_byte_en;

  modport master (
    input  i_req, i_wr, i_addr, i_wdata, i_ben, i_ack, i_rd_data,
    output o_ready, o_err, o_rdata, o_bus_en, o_wr_en, o_addr, o_wr_data, o_byte_en
  );

  modport slave (
    output i_req, i_wr, i_addr, i_wdata, i_ben, i_ack, i_rd_data,
    input  o_ready, o_err, o_rdata, o_bus_en, o_wr_en, o_addr, o_wr_data, o_byte_en
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin N-port bus arbiter: registered bus request one edge after grant, completion/error pulse combinational with i_ack or timeout.
// Requesters hold i_req until o_ready; bus stalls via i_ack, bounded by TIMEOUT; dropping i_req aborts without advancing rr.
module bus_arbiter #(
  parameter int N_PORTS = 2,
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          i_clk,
  input  logic          i_rst,
  bus_arbiter_if.master bif
);
  localparam int BE = XLEN / 8;
  localparam int AL = $clog2(BE);
  localparam int GW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [GW-1:0]   r_g;
  logic [GW-1:0]   r_rr;
  logic [CW-1:0]   r_cnt;
  logic            r_bus_en;
  logic            r_wr_en;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wr_data;
  logic [BE-1:0]   r_byte_en;

  logic            w_found;
  logic [GW-1:0]   w_gnt;
  logic [GW-1:0]   w_rr_adv;
  logic [XLEN-1:0] w_sel_addr;
  logic [XLEN-1:0] w_sel_wdata;
  logic [BE-1:0]   w_sel_ben;
  logic            w_sel_wr;
  logic [XLEN-1:0] w_bus_addr;
  logic [CW-1:0]   w_cnt_inc;
  logic            w_tmo_hit;
  logic            w_busy;
  logic            w_held;
  logic            w_abort;
  logic            w_ack_ok;
  logic            w_tmo;
  logic            w_done;
  logic [N_PORTS-1:0] w_ready;
  logic [N_PORTS-1:0] w_err;
  logic [XLEN-1:0]    w_rdata;

  // Reverse scan so the port closest to rr is the last (winning) assignment.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      if (bif.i_req[(int'(r_rr) + i) % N_PORTS]) begin
        w_found = 1'b1;
        w_gnt   = GW'((int'(r_rr) + i) % N_PORTS);
      end
    end
  end

  assign w_sel_addr  = bif.i_addr[w_gnt*XLEN +: XLEN];
  assign w_sel_wdata = bif.i_wdata[w_gnt*XLEN +: XLEN];
  assign w_sel_ben   = bif.i_ben[w_gnt*BE +: BE];
  assign w_sel_wr    = bif.i_wr[w_gnt];
  assign w_bus_addr  = w_sel_wr ? {w_sel_addr[XLEN-1:AL], AL'(0)} : w_sel_addr;

  assign w_rr_adv = (r_g == GW'(N_PORTS - 1)) ? '0 : r_g + 1'b1;

  // w_cnt_inc counts the current cycle too, so the TIMEOUT-th waiting cycle fires.
  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
  assign w_tmo_hit = (TIMEOUT != 0) && (w_cnt_inc == CW'(TIMEOUT));

  // A cycle with reset asserted never completes the in-flight transaction.
  assign w_busy   = (r_state == BUSY) && i_rst;
  assign w_held   = bif.i_req[r_g];
  assign w_abort  = w_busy && !w_held;
  assign w_ack_ok = w_busy && w_held && bif.i_ack;
  assign w_tmo    = w_busy && w_held && !bif.i_ack && w_tmo_hit;
  assign w_done   = w_ack_ok || w_tmo;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_found) w_state_nxt = BUSY;
      BUSY:    if (w_done || w_abort) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_ready = '0;
    w_err   = '0;
    w_rdata = '0;
    if (w_done) w_ready[r_g] = 1'b1;
    if (w_tmo) w_err[r_g] = 1'b1;
    if (w_ack_ok && !r_wr_en) w_rdata = bif.i_rd_data;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state   <= IDLE;
      r_g       <= '0;
      r_rr      <= '0;
      r_cnt     <= '0;
      r_bus_en  <= 1'b0;
      r_wr_en   <= 1'b0;
      r_addr    <= '0;
      r_wr_data <= '0;
      r_byte_en <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE) begin
        if (w_found) begin
          r_g       <= w_gnt;
          r_cnt     <= '0;
          r_bus_en  <= 1'b1;
          r_wr_en   <= w_sel_wr;
          r_addr    <= w_bus_addr;
          r_wr_data <= w_sel_wdata;
          r_byte_en <= w_sel_ben;
        end
      end else if (w_done || w_abort) begin
        r_bus_en <= 1'b0;
        r_wr_en  <= 1'b0;
        if (w_done) r_rr <= w_rr_adv;
      end else begin
        r_cnt <= w_cnt_inc;
      end
    end
  end

  assign bif.o_ready   = w_ready;
  assign bif.o_err     = w_err;
  assign bif.o_rdata   = w_rdata;
  assign bif.o_bus_en  = r_bus_en;
  assign bif.o_wr_en   = r_wr_en;
  assign bif.o_addr    = r_addr;
  assign bif.o_wr_data = r_wr_data;
  assign bif.o_byte_en = r_byte_en;
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: 2 ports, 32-bit bus, TIMEOUT=4.
module tb_bus_arbiter;
  localparam int NP = 2;
  localparam int XL = 32;

  logic i_clk = 1'b0;
  logic i_rst;
  int   n_chk = 0;
  int   n_err = 0;

  bus_arbiter_if #(.N_PORTS(NP), .XLEN(XL)) bif ();

  bus_arbiter #(.N_PORTS(NP), .XLEN(XL), .TIMEOUT(4)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bif   (bif)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] b, input logic w);
    bif.i_addr[p*XL +: XL]  = a;
    bif.i_wdata[p*XL +: XL] = d;
    bif.i_ben[p*4 +: 4]     = b;
    bif.i_wr[p]             = w;
  endtask

  initial begin
    i_rst         = 1'b0;
    bif.i_req     = '0;
    bif.i_wr      = '0;
    bif.i_addr    = '0;
    bif.i_wdata   = '0;
    bif.i_ben     = '0;
    bif.i_ack     = 1'b0;
    bif.i_rd_data = '0;
    repeat (2) tick();
    @(negedge i_clk);
    chk("rst_bus_en", bif.o_bus_en, 0);
    chk("rst_wr_en", bif.o_wr_en, 0);
    chk("rst_addr", bif.o_addr, 0);
    chk("rst_ready", bif.o_ready, 0);
    chk("rst_rdata", bif.o_rdata, 0);

    // Port 0 read, ack in the 3rd BUSY cycle.
    tick();
    i_rst = 1'b1;
    set_port(0, 32'h100, 32'h0, 4'hF, 1'b0);
    bif.i_req = 2'b01;
    @(negedge i_clk);
    chk("rd_idle_bus_en", bif.o_bus_en, 0);
    tick();
    @(negedge i_clk);
    chk("rd_bus_en", bif.o_bus_en, 1);
    chk("rd_addr", bif.o_addr, 32'h100);
    chk("rd_wr_en", bif.o_wr_en, 0);
    chk("rd_no_ready", bif.o_ready, 0);
    tick();
    tick();
    bif.i_ack     = 1'b1;
    bif.i_rd_data = 32'hDEADBEEF;
    @(negedge i_clk);
    chk("rd_ready", bif.o_ready, 2'b01);
    chk("rd_err", bif.o_err, 0);
    chk("rd_rdata", bif.o_rdata, 32'hDEADBEEF);
    tick();
    bif.i_ack = 1'b0;
    bif.i_req = 2'b00;
    @(negedge i_clk);
    chk("rd_done_bus_en", bif.o_bus_en, 0);
    chk("rd_done_ready", bif.o_ready, 0);
    chk("rd_done_rdata", bif.o_rdata, 0);

    // Port 1 write to an unaligned address; inputs change while BUSY.
    set_port(1, 32'h203, 32'h55, 4'b0010, 1'b1);
    bif.i_req = 2'b10;
    tick();
    @(negedge i_clk);
    chk("wr_addr", bif.o_addr, 32'h200);
    chk("wr_wr_en", bif.o_wr_en, 1);
    chk("wr_ben", bif.o_byte_en, 4'b0010);
    chk("wr_wdata", bif.o_wr_data, 32'h55);
    set_port(1, 32'hFFF, 32'hAA, 4'hF, 1'b0);
    tick();
    bif.i_ack     = 1'b1;
    bif.i_rd_data = 32'h1111;
    @(negedge i_clk);
    chk("wr_hold_addr", bif.o_addr, 32'h200);
    chk("wr_hold_wdata", bif.o_wr_data, 32'h55);
    chk("wr_hold_ben", bif.o_byte_en, 4'b0010);
    chk("wr_hold_wr_en", bif.o_wr_en, 1);
    chk("wr_ready", bif.o_ready, 2'b10);
    chk("wr_rdata_zero", bif.o_rdata, 0);
    tick();
    bif.i_ack = 1'b0;
    bif.i_req = 2'b00;
    @(negedge i_clk);
    chk("wr_done_bus_en", bif.o_bus_en, 0);
    chk("wr_done_wr_en", bif.o_wr_en, 0);

    // Port 0 read with no ack: timeout in the 4th BUSY cycle.
    bif.i_req = 2'b01;
    repeat (3) tick();
    @(negedge i_clk);
    chk("tmo_early_ready", bif.o_ready, 0);
    chk("tmo_early_err", bif.o_err, 0);
    tick();
    @(negedge i_clk);
    chk("tmo_ready", bif.o_ready, 2'b01);
    chk("tmo_err", bif.o_err, 2'b01);
    chk("tmo_rdata", bif.o_rdata, 0);
    tick();
    bif.i_req = 2'b00;
    @(negedge i_clk);
    chk("tmo_idle_bus_en", bif.o_bus_en, 0);

    // Port 1 read, ack coincides with timeout cycle: ack wins.
    set_port(1, 32'h300, 32'h0, 4'hF, 1'b0);
    bif.i_req = 2'b10;
    repeat (4) tick();
    bif.i_ack     = 1'b1;
    bif.i_rd_data = 32'h1234;
    @(negedge i_clk);
    chk("ackt_ready", bif.o_ready, 2'b10);
    chk("ackt_err", bif.o_err, 0);
    chk("ackt_rdata", bif.o_rdata, 32'h1234);
    tick();
    bif.i_ack = 1'b0;
    bif.i_req = 2'b00;

    // Port 0 aborts in its 2nd BUSY cycle; rr must not advance.
    bif.i_req = 2'b01;
    tick();
    tick();
    bif.i_req = 2'b00;
    @(negedge i_clk);
    chk("abort_no_ready", bif.o_ready, 0);
    tick();
    @(negedge i_clk);
    chk("abort_bus_en", bif.o_bus_en, 0);
    chk("abort_ready", bif.o_ready, 0);
    bif.i_req = 2'b11;
    tick();
    bif.i_ack = 1'b1;
    @(negedge i_clk);
    chk("abort_regrant_addr", bif.o_addr, 32'h100);
    chk("abort_regrant_ready", bif.o_ready, 2'b01);
    tick();
    bif.i_ack = 1'b0;
    bif.i_req = 2'b10;

    // Reset while port 1 is BUSY, with a coincident ack.
    tick();
    i_rst     = 1'b0;
    bif.i_ack = 1'b1;
    @(negedge i_clk);
    chk("mrst_addr_before", bif.o_addr, 32'h300);
    chk("mrst_no_ready", bif.o_ready, 0);
    tick();
    bif.i_ack = 1'b0;
    @(negedge i_clk);
    chk("mrst_bus_en", bif.o_bus_en, 0);
    chk("mrst_wr_en", bif.o_wr_en, 0);
    chk("mrst_addr", bif.o_addr, 0);
    chk("mrst_ben", bif.o_byte_en, 0);
    chk("mrst_ready", bif.o_ready, 0);
    i_rst     = 1'b1;
    bif.i_req = 2'b11;

    // Both ports request continuously: 0,1,0,1 with a single idle cycle between.
    for (int k = 0; k < 4; k++) begin
      tick();
      bif.i_ack = 1'b1;
      @(negedge i_clk);
      chk($sformatf("rr%0d_bus_en", k), bif.o_bus_en, 1);
      chk($sformatf("rr%0d_addr", k), bif.o_addr, (k % 2 == 0) ? 32'h100 : 32'h300);
      chk($sformatf("rr%0d_ready", k), bif.o_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
      tick();
      bif.i_ack = 1'b0;
      @(negedge i_clk);
      chk($sformatf("rr%0d_gap", k), bif.o_bus_en, 0);
    end

    // Late ack while IDLE is ignored.
    bif.i_req = 2'b00;
    bif.i_ack = 1'b1;
    @(posedge i_clk);
    #1;
    @(negedge i_clk);
    chk("late_ack_ready", bif.o_ready, 0);
    chk("late_ack_bus_en", bif.o_bus_en, 0);
    bif.i_ack = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
